// File: rtl/mem_arb_pkg.sv
// Shared state encoding and watchdog sizing for the MIPS memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEF = 32'sd255;
  localparam int ARB_CNT_W       = $clog2(ARB_TIMEOUT_DEF + 32'sd1);

  // A disabled watchdog (timeout 0) still needs a one-bit counter.
  function automatic int arb_cnt_width(input int timeout);
    return (timeout <= 32'sd0) ? 32'sd1 : $clog2(timeout + 32'sd1);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating wait counter for the arbiter: cleared on grant, counts while a
// memory access is outstanding, flags the cycle on which it reaches TIMEOUT.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = arb_cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  assign w_count_nxt = (r_count == LIMIT) ? r_count : r_count + CW'(1);

  // Wait counter register; holds at LIMIT instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_nxt;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (TIMEOUT > 32'sd0) && i_enable && (w_count_nxt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter sharing one variable-latency memory
// between the MIPS fetch and data ports, with a lost-handshake watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  arb_state_t    r_state,     w_state_nxt;
  logic          r_mem_req,   w_mem_req_nxt;
  logic          r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DW-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic [DW-1:0] r_dm_rdata,  w_dm_rdata_nxt;
  logic          r_if_done,   w_if_done_nxt;
  logic          r_dm_done,   w_dm_done_nxt;
  logic          r_discard,   w_discard_nxt;
  logic          r_bus_err,   w_bus_err_nxt;
  logic          w_grant, w_busy, w_expired, w_if_drop;

  // A port whose done is high is still presenting the request just served.
  assign if_stall  = if_req & ~r_if_done;
  assign dm_stall  = dm_req & ~r_dm_done;
  assign w_busy    = (r_state != ARB_IDLE);
  assign w_if_drop = r_discard | ~if_req | (if_addr != r_mem_addr);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_grant),
    .i_enable (w_busy),
    .o_expired(w_expired)
  );

  // Next-state and next-output logic; mem_ready beats a same-cycle timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;
    w_if_done_nxt   = 1'b0;
    w_dm_done_nxt   = 1'b0;
    w_discard_nxt   = r_discard;
    w_bus_err_nxt   = r_bus_err;
    w_grant         = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_discard_nxt = 1'b0;
        if (dm_stall) begin
          w_grant         = 1'b1;
          w_state_nxt     = ARB_BUSY_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = dm_we;
          w_mem_addr_nxt  = dm_addr;
          w_mem_wdata_nxt = dm_wdata;
        end else if (if_stall) begin
          w_grant         = 1'b1;
          w_state_nxt     = ARB_BUSY_I;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = if_addr;
          w_mem_wdata_nxt = '0;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ready || w_expired) begin
          w_state_nxt   = ARB_IDLE;
          w_mem_req_nxt = 1'b0;
          w_dm_done_nxt = 1'b1;
          w_bus_err_nxt = r_bus_err | ~mem_ready;
          if (!r_mem_we) begin
            w_dm_rdata_nxt = mem_ready ? mem_rdata : '0;
          end else begin
            w_dm_rdata_nxt = r_dm_rdata;
          end
        end else begin
          w_state_nxt = ARB_BUSY_D;
        end
      end
      ARB_BUSY_I: begin
        if (mem_ready || w_expired) begin
          w_state_nxt   = ARB_IDLE;
          w_mem_req_nxt = 1'b0;
          w_discard_nxt = 1'b0;
          w_bus_err_nxt = r_bus_err | ~mem_ready;
          if (!w_if_drop) begin
            w_if_done_nxt  = 1'b1;
            w_if_rdata_nxt = mem_ready ? mem_rdata : '0;
          end else begin
            w_if_rdata_nxt = r_if_rdata;
          end
        end else begin
          w_discard_nxt = w_if_drop;
        end
      end
      default: begin
        w_state_nxt   = ARB_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_discard   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
      r_if_done   <= w_if_done_nxt;
      r_dm_done   <= w_dm_done_nxt;
      r_discard   <= w_discard_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_done   = r_if_done;
  assign dm_rdata  = r_dm_rdata;
  assign dm_done   = r_dm_done;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-exact directed corner cases, then random fetch
// and data traffic scored against a word-addressed reference memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_done, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ready, bus_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          auto_mem, a_ready, m_ready, scb_on;
  logic [DW-1:0] a_rdata, m_rdata;
  assign mem_ready = auto_mem ? a_ready : m_ready;
  assign mem_rdata = auto_mem ? a_rdata : m_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [32:0] dm_q[$];
  logic [32:0] if_q[$];
  logic [31:0] last_dm;
  logic [32:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  // Random-latency memory: 0..4 wait cycles, checks request stability.
  int          busy_c = 0;
  int          tgt    = 0;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  initial begin
    a_ready = 1'b0;
    a_rdata = '0;
    forever begin
      tick();
      a_ready = 1'b0;
      if (auto_mem && mem_req) begin
        if (busy_c == 0) begin
          tgt = $urandom_range(0, 4);
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
        end else begin
          check("mem_addr_stable", mem_addr, s_addr);
          check("mem_we_stable", {31'b0, mem_we}, {31'b0, s_we});
          check("mem_wdata_stable", mem_wdata, s_wdata);
        end
        busy_c++;
        if (busy_c > tgt) begin
          a_ready = 1'b1;
          if (mem_we) phys_mem[mem_addr] = mem_wdata;
          else a_rdata = phys_read(mem_addr);
          busy_c = 0;
        end
      end else begin
        busy_c = 0;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (scb_on) begin
      check("if_stall_rule", {31'b0, if_stall}, {31'b0, if_req & ~if_done});
      check("dm_stall_rule", {31'b0, dm_stall}, {31'b0, dm_req & ~dm_done});
      if (dm_done) begin
        if (dm_q.size() == 0) begin
          n_checks++;
          $display("FAIL dm_done_unexpected: got dm_done=1, required no pending access (t=%0t)", $time);
        end else begin
          mon_e = dm_q.pop_front();
          if (mon_e[32]) begin
            check("dm_load_rdata", dm_rdata, mon_e[31:0]);
            last_dm = mon_e[31:0];
          end else begin
            check("dm_store_rdata_hold", dm_rdata, last_dm);
          end
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) begin
          n_checks++;
          $display("FAIL if_done_unexpected: got if_done=1, required no pending fetch (t=%0t)", $time);
        end else begin
          mon_e = if_q.pop_front();
          check("if_rdata", if_rdata, mon_e[31:0]);
        end
      end
    end
  end

  task automatic fetch_drv();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int waited;
      logic redir;
      a = 32'h0040_0000 | ($urandom_range(0, 255) << 2);
      if_addr = a; if_req = 1'b1;
      if_q.push_back({1'b1, ref_read(a)});
      waited = 0; redir = 1'b0;
      do begin
        tick();
        waited++;
        if (!if_done && !redir && $urandom_range(0, 5) == 0) begin
          a = a ^ 32'h0000_0040;
          if_addr = a;
          void'(if_q.pop_back());
          if_q.push_back({1'b1, ref_read(a)});
          redir = 1'b1;
        end
      end while (!if_done && waited < 200);
      check("if_done_seen", {31'b0, if_done}, 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b0;
        tick();
      end
    end
    if_req = 1'b0;
  endtask

  task automatic data_drv();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, d;
      logic we;
      int waited;
      a  = 32'h1001_0000 | ($urandom_range(0, 15) << 2);
      we = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      dm_addr = a; dm_we = we; dm_wdata = d; dm_req = 1'b1;
      if (we) begin
        ref_mem[a] = d;
        dm_q.push_back({1'b0, 32'h0000_0000});
      end else begin
        dm_q.push_back({1'b1, ref_read(a)});
      end
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!dm_done && waited < 200);
      check("dm_done_seen", {31'b0, dm_done}, 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        dm_req = 1'b0;
        tick();
      end
    end
    dm_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; auto_mem = 1'b0; m_ready = 1'b0; m_rdata = '0;
    scb_on = 1'b0; last_dm = '0;
    tick(); tick();
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_dones", {30'b0, if_done, dm_done}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_mem_req", {31'b0, mem_req}, 32'd0);

    // Both ports request; data wins, memory adds one wait state.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    tick();
    check("prio_grant_d", {31'b0, mem_req}, 32'd1);
    check("prio_addr_d", mem_addr, 32'h1001_0000);
    check("prio_we_d", {31'b0, mem_we}, 32'd0);
    tick();
    m_ready = 1'b1; m_rdata = 32'hCAFE_0001;
    tick();
    m_ready = 1'b0;
    check("prio_dm_done_c3", {31'b0, dm_done}, 32'd1);
    check("prio_dm_rdata", dm_rdata, 32'hCAFE_0001);
    check("prio_if_wait", {30'b0, if_done, if_stall}, 32'd1);
    check("prio_dm_stall_off", {31'b0, dm_stall}, 32'd0);
    dm_req = 1'b0;
    tick();
    check("prio_grant_i", {31'b0, mem_req}, 32'd1);
    check("prio_addr_i", mem_addr, 32'h0040_0000);
    tick();
    m_ready = 1'b1; m_rdata = 32'h2402_0005;
    tick();
    m_ready = 1'b0;
    check("prio_if_done_c6", {31'b0, if_done}, 32'd1);
    check("prio_if_rdata", if_rdata, 32'h2402_0005);
    if_req = 1'b0;
    tick();
    check("if_done_pulse", {31'b0, if_done}, 32'd0);

    // Fetch redirected while outstanding: old word discarded, new one fetched.
    if_req = 1'b1; if_addr = 32'h0040_0010;
    tick();
    check("redir_addr_old", mem_addr, 32'h0040_0010);
    if_addr = 32'h0040_0040;
    tick();
    m_ready = 1'b1; m_rdata = 32'h1111_0010;
    tick();
    m_ready = 1'b0;
    check("redir_no_done", {31'b0, if_done}, 32'd0);
    check("redir_rdata_kept", if_rdata, 32'h2402_0005);
    tick();
    check("redir_regrant", {31'b0, mem_req}, 32'd1);
    check("redir_addr_new", mem_addr, 32'h0040_0040);
    m_ready = 1'b1; m_rdata = 32'h2222_0040;
    tick();
    m_ready = 1'b0;
    check("redir_done", {31'b0, if_done}, 32'd1);
    check("redir_rdata", if_rdata, 32'h2222_0040);
    if_req = 1'b0;
    tick();

    // Store: request fields latched and stable, dm_rdata untouched.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_we", {31'b0, mem_we}, 32'd1);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    dm_addr = 32'h1001_0100; dm_wdata = 32'h0000_0000;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("st_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
      check("st_addr_stable", mem_addr, 32'h1001_0004);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("st_done", {31'b0, dm_done}, 32'd1);
    check("st_rdata_kept", dm_rdata, 32'hCAFE_0001);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("st_done_pulse", {31'b0, dm_done}, 32'd0);

    // Reset in the middle of a data access, then a stray mem_ready.
    dm_req = 1'b1; dm_addr = 32'h1001_0008;
    tick();
    check("rstmid_busy", {31'b0, mem_req}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rstmid_flags", {29'b0, bus_err, dm_done, if_done}, 32'd0);
    reset = 1'b0; dm_req = 1'b0;
    tick();
    check("rstmid_idle", {31'b0, mem_req}, 32'd0);
    m_ready = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    m_ready = 1'b0;
    check("late_ready_ignored", {30'b0, dm_done, if_done}, 32'd0);
    check("late_ready_rdata", dm_rdata, 32'd0);

    // mem_ready in the same cycle the watchdog would fire.
    dm_req = 1'b1; dm_addr = 32'h1001_000C;
    tick();
    for (int k = 2; k <= TO; k++) tick();
    m_ready = 1'b1; m_rdata = 32'h6666_0006;
    tick();
    m_ready = 1'b0;
    check("race_done", {31'b0, dm_done}, 32'd1);
    check("race_rdata", dm_rdata, 32'h6666_0006);
    check("race_no_err", {31'b0, bus_err}, 32'd0);
    dm_req = 1'b0;
    tick();

    // Memory never answers: watchdog ends the access after TO busy cycles.
    dm_req = 1'b1; dm_addr = 32'h1001_0010;
    tick();
    for (int k = 2; k <= TO; k++) begin
      tick();
      check("wd_still_busy", {30'b0, mem_req, bus_err}, 32'd2);
    end
    tick();
    check("wd_bus_err", {31'b0, bus_err}, 32'd1);
    check("wd_done", {31'b0, dm_done}, 32'd1);
    check("wd_rdata_zero", dm_rdata, 32'd0);
    check("wd_mem_req", {31'b0, mem_req}, 32'd0);
    dm_req = 1'b0;
    tick();
    check("wd_sticky", {30'b0, bus_err, dm_done}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("wd_err_cleared", {31'b0, bus_err}, 32'd0);

    // Random concurrent traffic against the scoreboard.
    auto_mem = 1'b1;
    last_dm  = '0;
    scb_on   = 1'b1;
    fork
      fetch_drv();
      data_drv();
    join
    for (int k = 0; k < 10; k++) tick();
    scb_on = 1'b0;
    check("if_q_drained", if_q.size(), 32'd0);
    check("dm_q_drained", dm_q.size(), 32'd0);
    check("rand_no_bus_err", {31'b0, bus_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
